baud_rate_gen: RTL and testbench
================================

Name: baud_rate_gen

Overview:
- Programmable baud clock generator for the UART transmitter.
- Divides the 50 MHz system clock `Clock` into a 50 %-duty square wave `BaudOut` at one of four standard baud rates.
- The rate is selected by the 2-bit `BaudRate` input.
- `BaudOut` paces the Tx shift register: one bit per `BaudOut` period, 1x rate, no oversampling.

Parameters:
- CLK_FREQ_HZ, 50_000_000, system clock frequency.
- CNT_W, 14, half-period counter width. It must hold the largest half-period count, 10417.

Ports:
- Clock  input  1  system clock; all logic on rising edge.
- ResetN  input  1  reset; synchronous and active-low.
- BaudRate  input  2  rate select: 00=2400, 01=4800, 10=9600, 11=19200 baud.
- BaudOut  output  1  baud-rate square wave, 50 % duty.

Behaviour:
- Half-period count HALF = round(CLK_FREQ_HZ / (2 × baud)). At 50 MHz:
  - 00 → 10417
  - 01 → 5208
  - 10 → 2604
  - 11 → 1302
- HALF is decoded combinationally from `BaudRate` on every cycle.
- Reset: on a rising `Clock` with `ResetN`=0, counter ← 0 and `BaudOut` ← 0. No other state exists.
- Normal operation, each rising edge with `ResetN`=1:
  - If counter >= HALF-1: counter ← 0 and `BaudOut` ← ~`BaudOut`.
  - Otherwise: counter ← counter+1.
- Timing:
  - `BaudOut` toggles every HALF cycles, so its period is 2·HALF cycles (19200 → 2604 cycles = 52.08 µs).
  - After reset is released, the first toggle (0→1) occurs on the HALF-th rising edge.
  - `BaudOut` is registered; there is no combinational path from inputs to output.
- `BaudRate` change mid-count:
  - Takes effect immediately; the counter is not restarted.
  - If the counter is already >= new HALF-1, the toggle happens on the next edge and the counter wraps to 0. The `>=` comparison guarantees no 2^14 overrun.
  - The first half-period after a change may therefore be shortened; all later half-periods are exact.
- Reset mid-count: counter and `BaudOut` are cleared on the next edge regardless of phase.
- Counter arithmetic is unsigned, CNT_W bits, and never exceeds HALF-1.

Decomposition:
- Shared uart package holds:
  - Baud select encodings: BAUD_2400=2'b00, BAUD_4800=2'b01, BAUD_9600=2'b10, BAUD_19200=2'b11.
  - Default CLK_FREQ_HZ.
  - A constant function computing HALF from clock frequency and baud, so Rx can reuse it with 16x oversampling.
- Single module; no sub-module needed. The HALF decode is an inline case statement.

Test Plan:
- Reset: hold `ResetN`=0 for 3 cycles with `BaudRate`=11 → `BaudOut`=0 and counter=0 throughout. On release, first rising edge of `BaudOut` occurs exactly 1302 cycles later.
- Per-rate period: for each `BaudRate` (11,10,01,00) held at least 3 periods → measured `BaudOut` high and low times are both HALF cycles, i.e. 1302/2604/5208/10417 cycles = 26.04/52.08/104.16/208.34 µs at 20 ns clock.
- Rate change down (11→10 mid-count at counter≈700) → current half-period completes at 2604 cycles. All subsequent half-periods are 2604.
- Rate change up (00→11 when counter≈8000) → `BaudOut` toggles on the next edge and the counter wraps. Subsequent half-periods are 1302; counter never exceeds 1301.
- Reset mid-operation: assert `ResetN`=0 while `BaudOut`=1 at counter≈500 → `BaudOut`=0 after the next edge. Count restarts from 0 on release.
- Sweep: `BaudRate` 11,10,01,00 each held for 250 µs → `BaudOut` edge counts consistent with 19200/9600/4800/2400 baud, with no glitches (no half-period shorter than the applicable HALF except the single post-change boundary case).

Source files
------------

// File: rtl/baud_rate_gen_pkg.sv
// Shared UART definitions: baud select encodings, default clock and the
// half-period helper that both the Tx generator and the oversampling Rx reuse.
package baud_rate_gen_pkg;

   localparam int DEFAULT_CLK_FREQ_HZ = 50_000_000;

   typedef enum logic [1:0] {
      BAUD_2400  = 2'b00,
      BAUD_4800  = 2'b01,
      BAUD_9600  = 2'b10,
      BAUD_19200 = 2'b11
   } baud_sel_e;

   localparam int BAUD_HZ_2400  = 2400;
   localparam int BAUD_HZ_4800  = 4800;
   localparam int BAUD_HZ_9600  = 9600;
   localparam int BAUD_HZ_19200 = 19200;

   // Rounded clk_hz / (2 * tick_hz); Rx passes 16x the baud rate here.
   function automatic int half_count(input int clk_hz, input int tick_hz);
      return (clk_hz + tick_hz) / (2 * tick_hz);
   endfunction

endpackage

// File: rtl/baud_rate_gen.sv
// Tx baud clock: 50 % duty square wave at one of four rates, one bit per period.
// The counter wraps on >= HALF-1 so a mid-count switch to a faster rate never overruns.
module baud_rate_gen
   import baud_rate_gen_pkg::*;
#(
   parameter int CLK_FREQ_HZ = DEFAULT_CLK_FREQ_HZ,
   parameter int CNT_W       = 14
) (
   input  logic       Clock,
   input  logic       ResetN,
   input  logic [1:0] BaudRate,
   output logic       BaudOut
);

   localparam logic [CNT_W-1:0] HALF_2400  = CNT_W'(half_count(CLK_FREQ_HZ, BAUD_HZ_2400));
   localparam logic [CNT_W-1:0] HALF_4800  = CNT_W'(half_count(CLK_FREQ_HZ, BAUD_HZ_4800));
   localparam logic [CNT_W-1:0] HALF_9600  = CNT_W'(half_count(CLK_FREQ_HZ, BAUD_HZ_9600));
   localparam logic [CNT_W-1:0] HALF_19200 = CNT_W'(half_count(CLK_FREQ_HZ, BAUD_HZ_19200));

   logic [CNT_W-1:0] half;
   logic [CNT_W-1:0] cnt;
   logic             wrap;

   always_comb begin
      half = HALF_2400;
      case (baud_sel_e'(BaudRate))
         BAUD_2400:  half = HALF_2400;
         BAUD_4800:  half = HALF_4800;
         BAUD_9600:  half = HALF_9600;
         BAUD_19200: half = HALF_19200;
         default:    half = HALF_2400;
      endcase
   end

   assign wrap = (cnt >= (half - CNT_W'(1)));

   always_ff @(posedge Clock) begin
      if (!ResetN) begin
         cnt     <= '0;
         BaudOut <= 1'b0;
      end else if (wrap) begin
         cnt     <= '0;
         BaudOut <= ~BaudOut;
      end else begin
         cnt     <= cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_baud_rate_gen.sv
// Directed bench for baud_rate_gen: per-rate vector table plus rate-change
// and mid-count reset sequences, all expectations hand-computed at 50 MHz.
module tb_baud_rate_gen;

   logic       Clock;
   logic       ResetN;
   logic [1:0] BaudRate;
   logic       BaudOut;

   int compared   = 0;
   int mismatched = 0;

   baud_rate_gen dut (
      .Clock    (Clock),
      .ResetN   (ResetN),
      .BaudRate (BaudRate),
      .BaudOut  (BaudOut)
   );

   initial Clock = 1'b0;
   always #10 Clock = ~Clock;

   typedef struct {
      logic [1:0] rate;
      int         half;
      int         window;
      int         toggles;
   } vec_t;

   vec_t vecs [4];

   task automatic check(input string name, input int act, input int exp);
      compared++;
      if (act != exp) begin
         mismatched++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge Clock);
      #1;
   endtask

   // Hold reset three edges, checking the cleared state each time, then release.
   task automatic do_reset(input logic [1:0] rate);
      BaudRate = rate;
      ResetN   = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         check("reset_baudout", int'(BaudOut), 0);
         check("reset_cnt", int'(dut.cnt), 0);
      end
      ResetN = 1'b1;
   endtask

   // Edges until BaudOut differs from its current value; -1 if the bound expires.
   task automatic edges_to_toggle(input int limit, output int n);
      logic start;
      start = BaudOut;
      n = 0;
      while (1) begin
         step();
         n++;
         if (BaudOut != start) return;
         if (n >= limit) begin
            n = -1;
            return;
         end
      end
   endtask

   initial begin
      int n;
      int toggles;
      int last_edge;
      int max_cnt;
      logic prev;

      ResetN   = 1'b0;
      BaudRate = 2'b11;

      vecs[0] = '{2'b11, 1302,  12500, 9};
      vecs[1] = '{2'b10, 2604,  12500, 4};
      vecs[2] = '{2'b01, 5208,  12500, 2};
      vecs[3] = '{2'b00, 10417, 21000, 2};

      // Per-rate: first toggle at HALF, every later half-period exactly HALF,
      // and the toggle count over the window matches the rate.
      foreach (vecs[v]) begin
         do_reset(vecs[v].rate);
         toggles   = 0;
         last_edge = 0;
         prev      = BaudOut;
         for (int e = 1; e <= vecs[v].window; e++) begin
            step();
            if (BaudOut != prev) begin
               toggles++;
               if (toggles == 1)
                  check($sformatf("first_toggle_r%0d", vecs[v].rate), e, vecs[v].half);
               else
                  check($sformatf("half_period_r%0d", vecs[v].rate), e - last_edge, vecs[v].half);
               last_edge = e;
               prev      = BaudOut;
            end
         end
         check($sformatf("toggle_count_r%0d", vecs[v].rate), toggles, vecs[v].toggles);
      end

      // Slow down mid-count: 11 -> 10 at counter 700; half-period ends at 2604.
      do_reset(2'b11);
      repeat (700) step();
      check("down_cnt_700", int'(dut.cnt), 700);
      BaudRate = 2'b10;
      edges_to_toggle(5000, n);
      check("down_first", n, 2604 - 700);
      check("down_level", int'(BaudOut), 1);
      for (int k = 0; k < 2; k++) begin
         edges_to_toggle(5000, n);
         check("down_steady", n, 2604);
      end

      // Speed up mid-count: 00 -> 11 at counter 8000 toggles on the next edge.
      do_reset(2'b00);
      repeat (8000) step();
      check("up_cnt_8000", int'(dut.cnt), 8000);
      BaudRate = 2'b11;
      step();
      check("up_toggle_now", int'(BaudOut), 1);
      check("up_wrap_cnt", int'(dut.cnt), 0);
      max_cnt = 0;
      for (int k = 0; k < 2; k++) begin
         prev = BaudOut;
         n = 0;
         while (BaudOut == prev && n < 3000) begin
            step();
            n++;
            if (int'(dut.cnt) > max_cnt) max_cnt = int'(dut.cnt);
         end
         check("up_steady", n, 1302);
      end
      check("up_max_cnt", max_cnt, 1301);

      // Reset while BaudOut is high at counter 500.
      do_reset(2'b11);
      edges_to_toggle(3000, n);
      check("mid_first", n, 1302);
      repeat (500) step();
      check("mid_level_hi", int'(BaudOut), 1);
      check("mid_cnt_500", int'(dut.cnt), 500);
      ResetN = 1'b0;
      step();
      check("mid_rst_baudout", int'(BaudOut), 0);
      check("mid_rst_cnt", int'(dut.cnt), 0);
      ResetN = 1'b1;
      step();
      check("mid_restart_cnt", int'(dut.cnt), 1);
      edges_to_toggle(3000, n);
      check("mid_restart_toggle", n, 1301);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
